// File: rtl/prbs_pkg.sv
// Shared types and defaults for the PRBS checker and its 3-bit LFSR generator.
package prbs_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam int         DEF_WIDTH = 3;
    localparam logic [2:0] DEF_TAPS  = 3'b110;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Serial input / link-status bundle between the received bit stream and the PRBS checker.
interface prbs_checker_if #(
    parameter int CNT_W = 16
);
    logic             din;
    logic             din_valid;
    logic             clr_cnt;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output din, din_valid, clr_cnt,
        input  locked, err, err_cnt
    );

    modport slave (
        input  din, din_valid, clr_cnt,
        output locked, err, err_cnt
    );
endinterface

// File: rtl/prbs_predict.sv
// Combinational next-bit predictor for a Fibonacci LFSR; also flags the illegal all-zero history.
module prbs_predict #(
    parameter int               WIDTH = prbs_pkg::DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(prbs_pkg::DEF_TAPS)
) (
    input  logic [WIDTH-1:0] hist_i,
    output logic             pred_o,
    output logic             zero_o
);
    assign pred_o = ^(hist_i & TAPS);
    assign zero_o = (hist_i == '0);
endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: hunts for WIDTH seed bits, qualifies LOCK_CNT matches,
// then reports mismatches with a saturating counter until UNLOCK_CNT misses in a row drop lock.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(DEF_TAPS),
    parameter int               LOCK_CNT   = 8,
    parameter int               UNLOCK_CNT = 4,
    parameter int               CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst,
    prbs_checker_if.slave  link
);
    localparam int               RUN_W   = $clog2(max3(WIDTH, LOCK_CNT, UNLOCK_CNT) + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hist_q, hist_d;
    logic [RUN_W-1:0] fill_q, fill_d;
    logic [RUN_W-1:0] good_q, good_d;
    logic [RUN_W-1:0] bad_q, bad_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic             pred, hist_zero, miss;

    prbs_predict #(.WIDTH(WIDTH), .TAPS(TAPS)) u_predict (
        .hist_i (hist_q),
        .pred_o (pred),
        .zero_o (hist_zero)
    );

    // An all-zero history would predict zeros forever, so it never counts as a match.
    assign miss = (link.din != pred) | hist_zero;

    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        good_d   = good_q;
        bad_d    = bad_q;
        err_d    = 1'b0;
        cnt_base = link.clr_cnt ? '0 : cnt_q;
        cnt_d    = cnt_base;

        if (link.din_valid) begin
            hist_d = {hist_q[WIDTH-2:0], link.din};
            unique case (state_q)
                HUNT: begin
                    if (fill_q == RUN_W'(WIDTH - 1)) begin
                        state_d = CHECK;
                        fill_d  = '0;
                        good_d  = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (miss) begin
                        good_d = '0;
                    end else if (good_q == RUN_W'(LOCK_CNT - 1)) begin
                        state_d = LOCKED;
                        bad_d   = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (miss) begin
                        err_d = 1'b1;
                        if (cnt_base != CNT_MAX) cnt_d = cnt_base + 1'b1;
                        if (bad_q == RUN_W'(UNLOCK_CNT - 1)) begin
                            state_d = HUNT;
                            fill_d  = '0;
                        end else begin
                            bad_d = bad_q + 1'b1;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            hist_q   <= '0;
            fill_q   <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign link.locked  = locked_q;
    assign link.err     = err_q;
    assign link.err_cnt = cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a 16-bit and a 2-bit counter instance share one stimulus stream.
module tb_prbs_checker;

    localparam int         WIDTH  = 3;
    localparam logic [2:0] TAPS   = 3'b110;
    localparam int         LOCKN  = 8;
    localparam int         UNLOCK = 4;

    typedef struct packed {
        logic        locked;
        logic        err;
        logic [15:0] c16;
        logic [1:0]  c2;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prbs_checker_if #(.CNT_W(16)) bus ();
    prbs_checker_if #(.CNT_W(2))  bus2 ();

    prbs_checker #(.CNT_W(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .link (bus)
    );

    prbs_checker #(.CNT_W(2)) dut_sat (
        .clk  (clk),
        .rst  (rst),
        .link (bus2)
    );

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: received bits (newest last), mode 0/1/2 = hunting/checking/locked.
    bit   rx[$];
    int   m_mode, m_fill, m_good, m_bad, m_c16, m_c2;
    bit   m_locked, m_err;
    bit   pat[7] = '{1, 1, 0, 0, 1, 0, 1};
    int   ppos;

    function automatic bit past_bit(int k);
        int idx;
        idx = rx.size() - 1 - k;
        return (idx >= 0) ? rx[idx] : 1'b0;
    endfunction

    task automatic model_step(input bit v, input bit d, input bit clr, input bit r);
        bit pred, zero, miss, counted;
        if (r) begin
            rx.delete();
            m_mode = 0; m_fill = 0; m_good = 0; m_bad = 0;
            m_c16 = 0; m_c2 = 0; m_locked = 0; m_err = 0;
            return;
        end
        counted = 0;
        if (v) begin
            pred = 0;
            zero = 1;
            for (int k = 0; k < WIDTH; k++) begin
                if (TAPS[k]) pred ^= past_bit(k);
                if (past_bit(k)) zero = 0;
            end
            miss = (d != pred) || zero;
            if (m_mode == 0) begin
                m_fill++;
                if (m_fill == WIDTH) begin m_mode = 1; m_good = 0; end
            end else if (m_mode == 1) begin
                if (miss) m_good = 0;
                else begin
                    m_good++;
                    if (m_good == LOCKN) begin m_mode = 2; m_bad = 0; end
                end
            end else begin
                if (miss) begin
                    counted = 1;
                    m_bad++;
                    if (m_bad == UNLOCK) begin m_mode = 0; m_fill = 0; end
                end else m_bad = 0;
            end
            rx.push_back(d);
            if (rx.size() > WIDTH) void'(rx.pop_front());
        end
        if (clr) begin m_c16 = 0; m_c2 = 0; end
        if (counted && m_c16 < 65535) m_c16++;
        if (counted && m_c2 < 3) m_c2++;
        m_err    = counted;
        m_locked = (m_mode == 2);
    endtask

    task automatic step(input bit v, input bit d, input bit clr, input bit r);
        exp_t e;
        @(negedge clk);
        rst = r;
        bus.din_valid = v;  bus2.din_valid = v;
        bus.din = d;        bus2.din = d;
        bus.clr_cnt = clr;  bus2.clr_cnt = clr;
        model_step(v, d, clr, r);
        e.locked = m_locked;
        e.err    = m_err;
        e.c16    = 16'(m_c16);
        e.c2     = 2'(m_c2);
        q.push_back(e);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        ppos = 0;
    endtask

    // Feed n valid pattern bits; optional idle cycle after each, optional inverted bit.
    task automatic feed(input int n, input bit stall, input int flip_at, input bit clr_on_flip);
        bit d, flip;
        for (int i = 0; i < n; i++) begin
            flip = (i == flip_at);
            d = pat[ppos] ^ flip;
            ppos = (ppos + 1) % 7;
            step(1'b1, d, flip && clr_on_flip, 1'b0);
            if (stall) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
    endtask

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("locked", int'(bus.locked), int'(e.locked));
                cmp("err", int'(bus.err), int'(e.err));
                cmp("err_cnt", int'(bus.err_cnt), int'(e.c16));
                cmp("locked_w2", int'(bus2.locked), int'(e.locked));
                cmp("err_cnt_w2", int'(bus2.err_cnt), int'(e.c2));
            end
        end
    end

    initial begin : driver
        bit v, flip;
        rst = 1'b1;
        bus.din = 0; bus.din_valid = 0; bus.clr_cnt = 0;
        bus2.din = 0; bus2.din_valid = 0; bus2.clr_cnt = 0;

        // Clean lock, then a single inverted bit while locked.
        do_reset(); do_reset();
        feed(20, 1'b0, -1, 1'b0);
        feed(15, 1'b0, 3, 1'b0);

        // Stalled stream: idle cycle after every valid bit.
        do_reset();
        feed(18, 1'b1, -1, 1'b0);

        // Spaced errors saturate the 2-bit counter, then clear coincident with an error.
        feed(10, 1'b0, 2, 1'b0);
        feed(10, 1'b0, 2, 1'b0);
        feed(10, 1'b0, 2, 1'b0);
        feed(10, 1'b0, 2, 1'b0);
        feed(10, 1'b0, 2, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);

        // Stuck-at-0 after lock: must unlock and never relock.
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset mid-CHECK and mid-LOCKED, relock each time.
        do_reset();
        feed(6, 1'b0, -1, 1'b0);
        do_reset();
        feed(14, 1'b0, -1, 1'b0);
        do_reset();
        feed(14, 1'b0, -1, 1'b0);

        // Randomized traffic: stalls, occasional bit errors, clears and resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                v = ($urandom_range(0, 3) != 0);
                flip = ($urandom_range(0, 19) == 0);
                if (v) begin
                    step(1'b1, pat[ppos] ^ flip, ($urandom_range(0, 29) == 0), 1'b0);
                    ppos = (ppos + 1) % 7;
                end else begin
                    step(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0), 1'b0);
                end
            end
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
